// File: rtl/pll_lock_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, qualifies a synchronized lock, then releases downstream reset.
// Optional macro PLL_AUTO_RELOCK_EN: a lock loss in RUN restarts the PLL instead of parking in FAULT.
module pll_lock_ctrl #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RELEASE_DELAY       = 64
) (
  input  logic       clki,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_cnt,
  output logic [2:0] state
);

  localparam int CNT_MAX = (PLL_RST_CYCLES > RELEASE_DELAY) ? PLL_RST_CYCLES : RELEASE_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ST_W    = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TO_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_DELAY - 1);
  localparam logic [ST_W-1:0]  ST_DONE  = ST_W'(LOCK_STABLE_CYCLES);
  localparam logic [TO_W-1:0]  TO_DONE  = TO_W'(LOCK_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_lk;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [ST_W-1:0]  r_stable;
  logic [ST_W-1:0]  w_stable_nxt;
  logic [TO_W-1:0]  r_timeout;
  logic [TO_W-1:0]  w_timeout_nxt;
  logic [7:0]       r_retry;
  logic             w_retry_inc;
  logic             w_lost;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = '0;
    w_stable_nxt  = '0;
    w_timeout_nxt = '0;
    w_retry_inc   = 1'b0;
    w_lost        = 1'b0;
    case (r_state)
      S_RESET_PLL: begin
        if (r_cnt == RST_LAST) w_state_nxt = S_WAIT_LOCK;
        else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      S_WAIT_LOCK: begin
        w_stable_nxt  = r_lk ? (r_stable + ST_W'(1)) : '0;
        w_timeout_nxt = r_timeout + TO_W'(1);
        // Acceptance is checked first so it wins a tie with the timeout.
        if (w_stable_nxt == ST_DONE) begin
          w_state_nxt   = S_RELEASE;
          w_stable_nxt  = '0;
          w_timeout_nxt = '0;
        end else if (w_timeout_nxt == TO_DONE) begin
          w_state_nxt   = S_RESET_PLL;
          w_retry_inc   = 1'b1;
          w_stable_nxt  = '0;
          w_timeout_nxt = '0;
        end
      end
      S_RELEASE: begin
        if (!r_lk) begin
          w_state_nxt = S_RESET_PLL;
          w_retry_inc = 1'b1;
        end else if (r_cnt == REL_LAST) begin
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!r_lk) begin
          w_lost      = 1'b1;
          w_retry_inc = 1'b1;
`ifdef PLL_AUTO_RELOCK_EN
          w_state_nxt = S_RESET_PLL;
`else
          w_state_nxt = S_FAULT;
`endif
        end
      end
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_RESET_PLL;
    endcase

    // A forced relock overrides everything; only a concurrent RUN lock loss still counts as a retry.
    if (force_relock && (r_state != S_RESET_PLL)) begin
      w_state_nxt   = S_RESET_PLL;
      w_cnt_nxt     = '0;
      w_stable_nxt  = '0;
      w_timeout_nxt = '0;
      w_retry_inc   = w_lost;
    end
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_lk      <= 1'b0;
      r_state   <= S_RESET_PLL;
      r_cnt     <= '0;
      r_stable  <= '0;
      r_timeout <= '0;
      r_retry   <= 8'd0;
    end else begin
      r_sync1   <= locked;
      r_lk      <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_stable  <= w_stable_nxt;
      r_timeout <= w_timeout_nxt;
      if (w_retry_inc && (r_retry != 8'hFF)) r_retry <= r_retry + 8'd1;
    end
  end

  assign state     = r_state;
  assign pll_rst   = (r_state == S_RESET_PLL);
  assign sys_rst_n = (r_state == S_RUN);
  assign ready     = (r_state == S_RUN);
  assign lock_lost = w_lost;
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl: table-driven nominal bring-up plus hand-written corner sequences.
module tb_pll_lock_ctrl;

  logic       clki = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retry_cnt;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

`ifdef PLL_AUTO_RELOCK_EN
  localparam logic [2:0] LOSS_ST  = 3'd0;
  localparam logic       LOSS_PLL = 1'b1;
`else
  localparam logic [2:0] LOSS_ST  = 3'd4;
  localparam logic       LOSS_PLL = 1'b0;
`endif

  always #5 clki = ~clki;

  pll_lock_ctrl #(
    .PLL_RST_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(64),
    .RELEASE_DELAY(16)
  ) dut (
    .clki(clki),
    .rst_n(rst_n),
    .locked(locked),
    .force_relock(force_relock),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .ready(ready),
    .lock_lost(lock_lost),
    .retry_cnt(retry_cnt),
    .state(state)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic       locked;
    int         ncyc;
    logic [2:0] st;
    logic       prst;
    logic       srst;
    logic       rdy;
    logic       lost;
    logic [7:0] retry;
  } vec_t;

  function automatic vec_t mk(string nm, logic rn, logic lk, int n, logic [2:0] st,
                              logic p, logic s, logic r, logic l, logic [7:0] c);
    vec_t v;
    v.name = nm; v.rst_n = rn; v.locked = lk; v.ncyc = n; v.st = st;
    v.prst = p; v.srst = s; v.rdy = r; v.lost = l; v.retry = c;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clki);
    #1;
  endtask

  task automatic do_reset();
    locked       = 1'b0;
    force_relock = 1'b0;
    rst_n        = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  vec_t tbl[10];
  logic saw_rel;

  initial begin
    // Edge numbering: E1 is the first clock edge after rst_n is released.
    tbl[0] = mk("reset",        1'b0, 1'b0, 2,  3'd0,    1'b1,     1'b0, 1'b0, 1'b0, 8'd0);
    tbl[1] = mk("rst_pll",      1'b1, 1'b0, 3,  3'd0,    1'b1,     1'b0, 1'b0, 1'b0, 8'd0);
    tbl[2] = mk("wait_enter",   1'b1, 1'b0, 1,  3'd1,    1'b0,     1'b0, 1'b0, 1'b0, 8'd0);
    tbl[3] = mk("wait_idle",    1'b1, 1'b0, 6,  3'd1,    1'b0,     1'b0, 1'b0, 1'b0, 8'd0);
    tbl[4] = mk("wait_stable",  1'b1, 1'b1, 9,  3'd1,    1'b0,     1'b0, 1'b0, 1'b0, 8'd0);
    tbl[5] = mk("release_in",   1'b1, 1'b1, 1,  3'd2,    1'b0,     1'b0, 1'b0, 1'b0, 8'd0);
    tbl[6] = mk("release_hold", 1'b1, 1'b1, 15, 3'd2,    1'b0,     1'b0, 1'b0, 1'b0, 8'd0);
    tbl[7] = mk("run_enter",    1'b1, 1'b1, 1,  3'd3,    1'b0,     1'b1, 1'b1, 1'b0, 8'd0);
    tbl[8] = mk("loss_detect",  1'b1, 1'b0, 2,  3'd3,    1'b0,     1'b1, 1'b1, 1'b1, 8'd0);
    tbl[9] = mk("loss_exit",    1'b1, 1'b0, 1,  LOSS_ST, LOSS_PLL, 1'b0, 1'b0, 1'b0, 8'd1);

    #1;
    for (int i = 0; i < 10; i++) begin
      rst_n  = tbl[i].rst_n;
      locked = tbl[i].locked;
      repeat (tbl[i].ncyc) tick();
      check({tbl[i].name, ".state"},     state,     tbl[i].st);
      check({tbl[i].name, ".pll_rst"},   pll_rst,   tbl[i].prst);
      check({tbl[i].name, ".sys_rst_n"}, sys_rst_n, tbl[i].srst);
      check({tbl[i].name, ".ready"},     ready,     tbl[i].rdy);
      check({tbl[i].name, ".lock_lost"}, lock_lost, tbl[i].lost);
      check({tbl[i].name, ".retry_cnt"}, retry_cnt, tbl[i].retry);
    end

`ifdef PLL_AUTO_RELOCK_EN
    repeat (4) tick();
    check("relock.state", state, 3'd1);
    check("relock.retry", retry_cnt, 8'd1);
`else
    repeat (5) tick();
    check("fault_hold.state", state, 3'd4);
    check("fault_hold.pll_rst", pll_rst, 1'b0);
    check("fault_hold.retry", retry_cnt, 8'd1);
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    check("fault_force.state", state, 3'd0);
    check("fault_force.pll_rst", pll_rst, 1'b1);
    check("fault_force.retry", retry_cnt, 8'd1);
`endif

    // Glitchy lock: 5-cycle runs never reach the 8-cycle stability window.
    do_reset();
    saw_rel = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      locked = (((i - 1) / 5) % 2) != 0;
      tick();
      if (state == 3'd2) saw_rel = 1'b1;
      if (i == 67) check("glitch.retry_before", retry_cnt, 8'd0);
      if (i == 68) begin
        check("glitch.retry_timeout", retry_cnt, 8'd1);
        check("glitch.state_timeout", state, 3'd0);
        check("glitch.pll_rst_on", pll_rst, 1'b1);
      end
      if (i == 71) check("glitch.pll_rst_hold", pll_rst, 1'b1);
      if (i == 72) check("glitch.pll_rst_off", pll_rst, 1'b0);
    end
    check("glitch.no_release", saw_rel, 1'b0);

    // Force relock coinciding with a RUN lock loss.
    do_reset();
    locked = 1'b1;
    for (int n = 0; n < 60 && !ready; n++) tick();
    check("prio.reach_run", ready, 1'b1);
    locked = 1'b0;
    for (int n = 0; n < 6 && !lock_lost; n++) tick();
    check("prio.lost_seen", lock_lost, 1'b1);
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    check("prio.state", state, 3'd0);
    check("prio.retry", retry_cnt, 8'd1);
    check("prio.lost_clear", lock_lost, 1'b0);
    check("prio.sys_rst_n", sys_rst_n, 1'b0);
    repeat (4) tick();
    check("prio.wait_after", state, 3'd1);
    check("prio.retry_after", retry_cnt, 8'd1);

    // Asynchronous reset mid-RELEASE, with a nonzero retry count to clear.
    locked = 1'b1;
    for (int n = 0; n < 40 && state != 3'd2; n++) tick();
    check("midrel.reach_release", state, 3'd2);
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    check("midrel.state", state, 3'd0);
    check("midrel.pll_rst", pll_rst, 1'b1);
    check("midrel.sys_rst_n", sys_rst_n, 1'b0);
    check("midrel.ready", ready, 1'b0);
    check("midrel.lock_lost", lock_lost, 1'b0);
    check("midrel.retry", retry_cnt, 8'd0);
    tick();
    check("midrel.held", state, 3'd0);
    rst_n = 1'b1;

    // Saturation: each failed attempt is 4 reset cycles plus a 64-cycle timeout.
    do_reset();
    repeat (254 * 68) tick();
    check("sat.254", retry_cnt, 8'd254);
    repeat (68) tick();
    check("sat.255", retry_cnt, 8'd255);
    repeat (45 * 68) tick();
    check("sat.hold", retry_cnt, 8'd255);
    check("sat.state", state, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
